// File: rtl/fifo_rd_packer_pkg.sv
// fifo_rd_packer shared definitions
// counter widths and lane keep-mask helper
package fifo_rd_packer_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_RATIO   = 4;
  localparam int DEF_TIMEOUT = 16;
  localparam int MAX_LANES   = 32;

  function automatic int cnt_w(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  function automatic int idle_w(input int timeout);
    return $clog2(timeout);
  endfunction

  localparam int CNT_W  = cnt_w(DEF_RATIO);
  localparam int IDLE_W = idle_w(DEF_TIMEOUT);

  // low cnt lanes set, the rest clear
  function automatic logic [MAX_LANES-1:0] keep_mask(
    input int unsigned cnt
  );
    logic [MAX_LANES-1:0] m;
    for (int i = 0; i < MAX_LANES; i++) begin
      m[i] = (32'(i) < cnt);
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_oreg.sv
// fifo_rd_packer output holding register
// a loaded beat stays put until the sink takes it
module fifo_rd_packer_oreg #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic [KW-1:0] keep_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [KW-1:0] keep_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic [KW-1:0] keep_q;

  // load wins over a same-cycle accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: FWFT FIFO reader that packs
// RATIO words per wide beat, closing partials
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int RATIO   = DEF_RATIO,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_dout,
  output logic                   fifo_pop,
  input  logic                   flush,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH*RATIO-1:0] m_data,
  output logic [RATIO-1:0]       m_keep
);

  localparam int CW = cnt_w(RATIO);
  localparam int IW = idle_w(TIMEOUT);
  localparam int DW = WIDTH * RATIO;
  localparam logic [CW-1:0] FULL = CW'(RATIO);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

  logic [DW-1:0] acc_data_q, acc_data_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          close_q, close_d;

  logic                 full, partial;
  logic                 xfer, can_take, pop;
  logic [CW-1:0]        lane;
  logic [MAX_LANES-1:0] keep_all;
  logic [RATIO-1:0]     beat_keep;
  logic [DW-1:0]        beat_data;

  assign full    = (acc_cnt_q == FULL);
  assign partial = (acc_cnt_q != '0) && !full;

  assign xfer = (full | (close_q & (acc_cnt_q != '0)))
              & (!m_valid | m_ready);

  assign can_take = (!full & !close_q) | xfer;
  assign pop      = !fifo_empty & !rst & can_take;
  assign fifo_pop = pop;

  // a pop alongside xfer starts the next beat
  assign lane = xfer ? '0 : acc_cnt_q;

  assign keep_all  = keep_mask(32'(acc_cnt_q));
  assign beat_keep = keep_all[RATIO-1:0];

  // unfilled lanes leave as zero
  always_comb begin
    beat_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (beat_keep[i]) begin
        beat_data[i*WIDTH +: WIDTH] =
          acc_data_q[i*WIDTH +: WIDTH];
      end
    end
  end

  // accumulate, idle timeout and close request
  always_comb begin
    acc_data_d = acc_data_q;
    acc_cnt_d  = acc_cnt_q;
    idle_d     = idle_q;
    close_d    = close_q;
    if (xfer) begin
      acc_data_d = '0;
      acc_cnt_d  = '0;
      close_d    = 1'b0;
    end
    if (pop) begin
      for (int i = 0; i < RATIO; i++) begin
        if (lane == CW'(i)) begin
          acc_data_d[i*WIDTH +: WIDTH] = fifo_dout;
        end
      end
      acc_cnt_d = acc_cnt_d + CW'(1);
    end
    if (pop | xfer) begin
      idle_d = '0;
    end else if (partial) begin
      if (idle_q == IDLE_MAX) begin
        close_d = 1'b1;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end
    if (flush && (acc_cnt_d != '0)) begin
      close_d = 1'b1;
    end
  end

  // accumulator state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_data_q <= '0;
      acc_cnt_q  <= '0;
      idle_q     <= '0;
      close_q    <= 1'b0;
    end else begin
      acc_data_q <= acc_data_d;
      acc_cnt_q  <= acc_cnt_d;
      idle_q     <= idle_d;
      close_q    <= close_d;
    end
  end

  fifo_rd_packer_oreg #(
    .DW (DW),
    .KW (RATIO)
  ) u_oreg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (xfer),
    .data_i  (beat_data),
    .keep_i  (beat_keep),
    .ready_i (m_ready),
    .valid_o (m_valid),
    .data_o  (m_data),
    .keep_o  (m_keep)
  );

endmodule
